mult_div_sequencer: RTL and testbench
=====================================

Name: mult_div_sequencer

Overview:
- Multi-cycle sequencer for signed MULT/DIV. Drives an iterative Booth multiplier and a restoring divider from operands A/B, and latches results into the hi/lo outputs that feed the HI/LO mult/div registers.
- Reports completion and divide-by-zero to the control unit through a start/busy/done handshake.
- The control unit stalls in its mult/div states until done or div0.

Parameters:
- WIDTH, 32, operand and result half-width; iteration count per operation.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low; clears all state when 0.
- start, input, 1, request pulse; sampled only in IDLE.
- op, input, 1, operation select: 0 = MULT, 1 = DIV.
- a_in, input, WIDTH, multiplicand or dividend; sampled with start.
- b_in, input, WIDTH, multiplier or divisor; sampled with start.
- busy, output, 1, high from the cycle after start is accepted until done/div0 is asserted.
- done, output, 1, one-cycle pulse when hi/lo hold a new result.
- div0, output, 1, one-cycle pulse when a DIV is requested with divisor 0.
- hi_out, output, WIDTH, MULT upper product or DIV remainder.
- lo_out, output, WIDTH, MULT lower product or DIV quotient.

Behaviour:
- Reset (reset=0, async): state=IDLE; busy=0, done=0, div0=0, hi_out=0, lo_out=0; internal accumulators cleared. Reset mid-operation aborts, and hi/lo read 0.
- States: IDLE, MULT, DIV, FIX, DONE, ZERO.
- IDLE:
  - start=1, op=0: latch operands, cnt=0 -> MULT.
  - start=1, op=1, b_in!=0: latch magnitudes and signs -> DIV.
  - start=1, op=1, b_in==0: -> ZERO.
- MULT: radix-2 Booth, one step per cycle on a 2*WIDTH+1 accumulator with arithmetic right shift. After WIDTH steps -> FIX.
- DIV: restoring division on magnitudes, one quotient bit per cycle. After WIDTH steps -> FIX.
- FIX:
  - MULT: copy the product to hi/lo.
  - DIV: quotient negated if the operand signs differ; remainder takes the dividend's sign (truncation toward zero).
  - Registers hi_out/lo_out -> DONE.
- DONE: done=1 for this cycle only -> IDLE.
- ZERO: div0=1 for one cycle; hi_out/lo_out unchanged -> IDLE.
- Latency: start accepted at edge 0, done high in cycle WIDTH+2 (34 for WIDTH=32). div0 high in cycle 1.
- busy=1 in MULT, DIV, FIX; busy=0 in IDLE, DONE, ZERO.
- start while not IDLE is ignored; no queueing.
- Operand changes after acceptance have no effect.
- hi_out/lo_out hold their value until the next FIX or reset.
- Overflow: 0x80000000 / -1 gives lo=0x80000000, hi=0 (two's-complement wrap, no flag).
- Product of -2^31 * -2^31 is exact: hi=0x40000000, lo=0.

Optional Feature:
- Macro: MULT_DIV_UNSIGNED_EN.
- Defined: adds input port is_unsigned (1 bit), sampled with start. When 1, operands are treated as unsigned (MULTU/DIVU): no Booth sign extension and no sign fix in FIX. Latency is identical.
- Undefined: the port is absent and all operations are signed.

Decomposition:
- Package mult_div_pkg: state enum (IDLE, MULT, DIV, FIX, DONE, ZERO), op encoding constants OP_MULT=0 and OP_DIV=1, default WIDTH.
- One natural sub-module: div_step, a combinational single restoring-division step (remainder, divisor, next dividend bit -> new remainder, quotient bit), instantiated once in the DIV iteration.

Test Plan:
- MULT 7 * -3: hi=0xFFFFFFFF, lo=0xFFFFFFEB; done in cycle 34; busy high in cycles 1..33.
- DIV 7 / -2: lo=0xFFFFFFFD, hi=0x00000001. Then DIV -7 / 2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 5 / 0: div0 pulse in cycle 1, no done, hi/lo keep their previous values, busy stays 0.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. MULT 0x80000000 * 0x80000000: hi=0x40000000, lo=0.
- start re-asserted in cycle 10 of a MULT with different operands: ignored, first result correct, done exactly once.
- reset driven low in cycle 15 of a DIV: outputs 0 immediately (async); after release, a new MULT 3*4 gives lo=12, hi=0.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared types and constants for the multi-cycle MULT/DIV sequencer.
package mult_div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIX,
        DONE,
        ZERO
    } state_e;

endpackage

// File: rtl/mult_div_sequencer_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;

    assign shifted = {rem_i, bit_i};
    // rem_i < divisor_i, so a successful subtraction always fits back into WIDTH bits.
    assign trial   = shifted[WIDTH-1:0] - divisor_i;
    assign q_o     = (shifted >= {1'b0, divisor_i});
    assign rem_o   = q_o ? trial : shifted[WIDTH-1:0];

endmodule

// File: rtl/mult_div_sequencer.sv
// Iterative signed Booth multiplier / restoring divider with start/busy/done handshake.
// Optional macro MULT_DIV_UNSIGNED_EN adds the is_unsigned input (MULTU/DIVU).
module mult_div_sequencer
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
`ifdef MULT_DIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int PW    = WIDTH + 2;   // Booth partial-product width with headroom

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    acc_q, acc_d;     // Booth upper half, or division remainder
    logic [PW-1:0]    m_q, m_d;         // extended multiplicand, or divisor magnitude
    logic [WIDTH-1:0] sh_q, sh_d;       // multiplier/product low, or dividend/quotient
    logic             qm1_q, qm1_d;
    logic             op_q, op_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             corr_q, corr_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             uns;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [PW-1:0]    booth_sum;
    logic [WIDTH-1:0] rem_nx;
    logic             q_bit;
    logic             last_step;

`ifdef MULT_DIV_UNSIGNED_EN
    assign uns = is_unsigned;
`else
    assign uns = 1'b0;
`endif

    assign a_neg     = ~uns & a_in[WIDTH-1];
    assign b_neg     = ~uns & b_in[WIDTH-1];
    assign a_mag     = a_neg ? -a_in : a_in;
    assign b_mag     = b_neg ? -b_in : b_in;
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        unique case ({sh_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + m_q;
            2'b10:   booth_sum = acc_q - m_q;
            default: booth_sum = acc_q;
        endcase
    end

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (acc_q[WIDTH-1:0]),
        .divisor_i (m_q[WIDTH-1:0]),
        .bit_i     (sh_q[WIDTH-1]),
        .rem_o     (rem_nx),
        .q_o       (q_bit)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        m_d       = m_q;
        sh_d      = sh_q;
        qm1_d     = qm1_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        corr_d    = corr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d  = op;
                    cnt_d = '0;
                    acc_d = '0;
                    qm1_d = 1'b0;
                    if (op == OP_MULT) begin
                        m_d     = uns ? {2'b00, a_in} : {{2{a_in[WIDTH-1]}}, a_in};
                        sh_d    = b_in;
                        // Booth reads the multiplier MSB as negative; unsigned adds it back.
                        corr_d  = uns & b_in[WIDTH-1];
                        state_d = MULT;
                    end else if (b_in != '0) begin
                        m_d       = {2'b00, b_mag};
                        sh_d      = a_mag;
                        neg_quo_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        state_d   = DIV;
                    end else begin
                        state_d = ZERO;
                    end
                end
            end
            MULT: begin
                acc_d = {booth_sum[PW-1], booth_sum[PW-1:1]};
                sh_d  = {booth_sum[0], sh_q[WIDTH-1:1]};
                qm1_d = sh_q[0];
                cnt_d = cnt_q + 1'b1;
                if (last_step) state_d = FIX;
            end
            DIV: begin
                acc_d = {2'b00, rem_nx};
                sh_d  = {sh_q[WIDTH-2:0], q_bit};
                cnt_d = cnt_q + 1'b1;
                if (last_step) state_d = FIX;
            end
            FIX: begin
                if (op_q == OP_MULT) begin
                    hi_d = acc_q[WIDTH-1:0] + (corr_q ? m_q[WIDTH-1:0] : '0);
                    lo_d = sh_q;
                end else begin
                    hi_d = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    lo_d = neg_quo_q ? -sh_q : sh_q;
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            ZERO:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            m_q       <= '0;
            sh_q      <= '0;
            qm1_q     <= 1'b0;
            op_q      <= OP_MULT;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            corr_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            sh_q      <= sh_d;
            qm1_q     <= qm1_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            corr_q    <= corr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy   = (state_q == MULT) || (state_q == DIV) || (state_q == FIX);
    assign done   = (state_q == DONE);
    assign div0   = (state_q == ZERO);
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench for mult_div_sequencer (WIDTH=32): directed table, random ops vs. arithmetic model.
module tb_mult_div_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic        is_unsigned;
    logic [31:0] a_in, b_in;
    logic        busy, done, div0;
    logic [31:0] hi_out, lo_out;

    int n_checks = 0;
    int n_errors = 0;

    mult_div_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
`ifdef MULT_DIV_UNSIGNED_EN
        .is_unsigned (is_unsigned),
`endif
        .a_in        (a_in),
        .b_in        (b_in),
        .busy        (busy),
        .done        (done),
        .div0        (div0),
        .hi_out      (hi_out),
        .lo_out      (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic, SV division truncates toward zero.
    task automatic model(input logic op_v, input logic [31:0] a, input logic [31:0] b,
                         input logic uns_v, output logic [31:0] hi, output logic [31:0] lo,
                         output logic is_zero);
        longint    sa, sb, q, r;
        logic [63:0] p;
        is_zero = 1'b0;
        hi = '0;
        lo = '0;
        if (op_v == 1'b0) begin
            if (uns_v) p = {32'b0, a} * {32'b0, b};
            else begin
                sa = $signed(a);
                sb = $signed(b);
                p  = sa * sb;
            end
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'b0) begin
            is_zero = 1'b1;
        end else begin
            if (uns_v) begin
                sa = {32'b0, a};
                sb = {32'b0, b};
            end else begin
                sa = $signed(a);
                sb = $signed(b);
            end
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end
    endtask

    // Issues one operation and watches 40 cycles; cycle 1 follows the accepting edge.
    task automatic run_op(input logic op_v, input logic [31:0] a, input logic [31:0] b,
                          input logic uns_v, input int restart, input logic exp_zero,
                          output int done_cyc, output int div0_cyc, output int n_done,
                          output int busy_bad);
        done_cyc = -1;
        div0_cyc = -1;
        n_done   = 0;
        busy_bad = 0;
        @(posedge clk);
        #1;
        start = 1'b1; op = op_v; a_in = a; b_in = b; is_unsigned = uns_v;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in = $urandom(); b_in = $urandom(); is_unsigned = ~uns_v;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (div0 && div0_cyc < 0) div0_cyc = cyc;
            if (busy !== ((!exp_zero) && cyc >= 1 && cyc <= 33)) busy_bad++;
            if (cyc == restart) begin
                start = 1'b1; op = 1'b0; a_in = 32'd3; b_in = 32'd3;
            end else if (cyc == restart + 1) begin
                start = 1'b0;
            end
        end
    endtask

    typedef struct {
        string       name;
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        zero;
        int          restart;
    } vec_t;

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0;
            1:       v = 32'h1;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h8000_0000;
            4:       v = 32'h7FFF_FFFF;
            5:       v = $urandom_range(0, 255);
            default: v = $urandom();
        endcase
        return v;
    endfunction

    vec_t        vecs[7];
    int          done_cyc, div0_cyc, n_done, busy_bad;
    logic [31:0] exp_hi, exp_lo, prev_hi, prev_lo;
    logic        exp_zero, uns_v, op_v;
    logic [31:0] ra, rb;

    initial begin
        vecs[0] = '{"mult_7_m3",      1'b0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, -5};
        vecs[1] = '{"div_7_m2",       1'b1, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, -5};
        vecs[2] = '{"div_m7_2",       1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, -5};
        vecs[3] = '{"div_5_0",        1'b1, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, -5};
        vecs[4] = '{"div_ovf",        1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, -5};
        vecs[5] = '{"mult_min_min",   1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, -5};
        vecs[6] = '{"mult_restart",   1'b0, 32'h0001_2345, 32'h0000_1000, 32'h0000_0000, 32'h1234_5000, 1'b0, 10};

        reset = 1'b0; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0; is_unsigned = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_div0", div0, 1'b0);
        check("rst_hi", hi_out, 32'h0);
        check("rst_lo", lo_out, 32'h0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, vecs[i].restart, vecs[i].zero,
                   done_cyc, div0_cyc, n_done, busy_bad);
            check({vecs[i].name, "_hi"}, hi_out, vecs[i].hi);
            check({vecs[i].name, "_lo"}, lo_out, vecs[i].lo);
            check({vecs[i].name, "_done_cyc"}, done_cyc, vecs[i].zero ? -1 : 34);
            check({vecs[i].name, "_ndone"}, n_done, vecs[i].zero ? 0 : 1);
            check({vecs[i].name, "_div0_cyc"}, div0_cyc, vecs[i].zero ? 1 : -1);
            check({vecs[i].name, "_busy"}, busy_bad, 0);
        end
        prev_hi = hi_out;
        prev_lo = lo_out;
        // Seed the model's held values from the last table entry's constants.
        prev_hi = vecs[6].hi;
        prev_lo = vecs[6].lo;

        for (int n = 0; n < 40; n++) begin
            op_v = $urandom_range(0, 1);
            ra   = pick();
            rb   = pick();
`ifdef MULT_DIV_UNSIGNED_EN
            uns_v = $urandom_range(0, 1);
`else
            uns_v = 1'b0;
`endif
            model(op_v, ra, rb, uns_v, exp_hi, exp_lo, exp_zero);
            if (exp_zero) begin
                exp_hi = prev_hi;
                exp_lo = prev_lo;
            end
            run_op(op_v, ra, rb, uns_v, -5, exp_zero, done_cyc, div0_cyc, n_done, busy_bad);
            check("rand_hi", hi_out, exp_hi);
            check("rand_lo", lo_out, exp_lo);
            check("rand_done_cyc", done_cyc, exp_zero ? -1 : 34);
            check("rand_div0_cyc", div0_cyc, exp_zero ? 1 : -1);
            check("rand_busy", busy_bad, 0);
            prev_hi = exp_hi;
            prev_lo = exp_lo;
        end

        // Make sure hi/lo are nonzero before the mid-operation reset.
        run_op(1'b0, 32'd5, 32'd9, 1'b0, -5, 1'b0, done_cyc, div0_cyc, n_done, busy_bad);
        check("pre_rst_lo", lo_out, 32'd45);

        @(posedge clk);
        #1;
        start = 1'b1; op = 1'b1; a_in = 32'd100; b_in = 32'd7; is_unsigned = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(negedge clk);
        check("mid_div_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("abort_hi", hi_out, 32'h0);
        check("abort_lo", lo_out, 32'h0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        run_op(1'b0, 32'd3, 32'd4, 1'b0, -5, 1'b0, done_cyc, div0_cyc, n_done, busy_bad);
        check("post_rst_hi", hi_out, 32'd0);
        check("post_rst_lo", lo_out, 32'd12);
        check("post_rst_done_cyc", done_cyc, 34);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
